// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: synchroniser, framing with parity/stop/watchdog
// checks, and a show-ahead byte FIFO drained by a valid/ready consumer.
module ps2_rx_fifo #(
    parameter int SYNC_STAGES    = 2,
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int CNT_W          = 8
) (
    input  logic                          clk,
    input  logic                          i_rst_n,
    input  logic                          i_sclr,
    input  logic                          i_ps2_clk,
    input  logic                          i_ps2_dat,
    output logic [7:0]                    o_data,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic [$clog2(FIFO_DEPTH):0]   o_level,
    output logic [CNT_W-1:0]              o_frame_cnt,
    output logic [CNT_W-1:0]              o_err_cnt,
    output logic                          o_parity_err,
    output logic                          o_frame_err,
    output logic                          o_overflow
);

    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [SYNC_STAGES-1:0] csync_q;
    logic [SYNC_STAGES-1:0] dsync_q;
    logic                   cprev_q;
    logic                   clk_s;
    logic                   dat_s;
    logic                   fall;

    state_t                 state_q, state_d;
    logic [2:0]             idx_q, idx_d;
    logic [7:0]             sh_q, sh_d;
    logic                   par_q, par_d;
    logic [WD_W-1:0]        wd_q, wd_d;
    logic                   push_d, perr_d, ferr_d;

    logic                   push_q;
    logic [7:0]             pdata_q;
    logic                   perr_q, ferr_q;
    logic [CNT_W-1:0]       fcnt_q, ecnt_q;
    logic                   ovf_q;

    logic [7:0]             mem [FIFO_DEPTH];
    logic [AW-1:0]          wptr_q, rptr_q;
    logic [AW:0]            count_q;
    logic                   full;
    logic                   pop;
    logic                   wr;

    assign clk_s = csync_q[SYNC_STAGES-1];
    assign dat_s = dsync_q[SYNC_STAGES-1];
    assign fall  = cprev_q & ~clk_s;

    // Synchronisers idle high like the bus, so reset never fakes an edge
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            csync_q <= '1;
            dsync_q <= '1;
            cprev_q <= 1'b1;
        end else if (i_sclr) begin
            csync_q <= '1;
            dsync_q <= '1;
            cprev_q <= 1'b1;
        end else begin
            csync_q <= {csync_q[SYNC_STAGES-2:0], i_ps2_clk};
            dsync_q <= {dsync_q[SYNC_STAGES-2:0], i_ps2_dat};
            cprev_q <= clk_s;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        sh_d    = sh_q;
        par_d   = par_q;
        wd_d    = wd_q;
        push_d  = 1'b0;
        perr_d  = 1'b0;
        ferr_d  = 1'b0;
        if (fall) begin
            wd_d = '0;
            unique case (state_q)
                IDLE: begin
                    if (!dat_s) begin
                        state_d = DATA;
                        idx_d   = 3'd0;
                    end
                end
                DATA: begin
                    sh_d  = {dat_s, sh_q[7:1]};
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'd7) state_d = PARITY;
                end
                PARITY: begin
                    par_d   = dat_s;
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (!dat_s)             ferr_d = 1'b1;
                    else if (^{sh_q, par_q}) push_d = 1'b1;
                    else                    perr_d = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE) begin
            if (wd_q == WD_LAST) begin
                state_d = IDLE;
                ferr_d  = 1'b1;
                wd_d    = '0;
            end else begin
                wd_d = wd_q + WD_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            sh_q    <= '0;
            par_q   <= 1'b0;
            wd_q    <= '0;
            push_q  <= 1'b0;
            pdata_q <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ecnt_q  <= '0;
        end else if (i_sclr) begin
            state_q <= IDLE;
            idx_q   <= '0;
            sh_q    <= '0;
            par_q   <= 1'b0;
            wd_q    <= '0;
            push_q  <= 1'b0;
            pdata_q <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ecnt_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            par_q   <= par_d;
            wd_q    <= wd_d;
            push_q  <= push_d;
            pdata_q <= sh_q;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            ecnt_q  <= ecnt_q + CNT_W'(perr_d | ferr_d);
        end
    end

    assign full = (count_q == (AW+1)'(FIFO_DEPTH));
    assign pop  = o_valid & i_ready;
    // A full FIFO still accepts a byte when a pop frees a slot in the same cycle
    assign wr   = push_q & (~full | pop);

    always_ff @(posedge clk) begin
        if (wr) mem[wptr_q] <= pdata_q;
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            fcnt_q  <= '0;
            ovf_q   <= 1'b0;
        end else if (i_sclr) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            fcnt_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (wr)  wptr_q <= wptr_q + AW'(1);
            if (pop) rptr_q <= rptr_q + AW'(1);
            unique case ({wr, pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
            fcnt_q <= fcnt_q + CNT_W'(push_q);
            if (push_q & full & ~pop) ovf_q <= 1'b1;
        end
    end

    assign o_valid      = (count_q != '0);
    assign o_data       = o_valid ? mem[rptr_q] : 8'h00;
    assign o_level      = count_q;
    assign o_frame_cnt  = fcnt_q;
    assign o_err_cnt    = ecnt_q;
    assign o_parity_err = perr_q;
    assign o_frame_err  = ferr_q;
    assign o_overflow   = ovf_q;

endmodule
